// File: rtl/calc_param_if.sv
// Keypad-to-display bus for calc_param: command strobe in,
// BCD print stream and status out.
interface calc_param_if #(
  parameter int POS_W = 4
);
  logic [3:0]       cmd;
  logic             cmd_valid;
  logic [1:0]       status;
  logic [3:0]       data;
  logic [POS_W-1:0] pos;
  logic             data_valid;
  logic [2:0]       EA;

  modport master (
    output cmd, cmd_valid,
    input  status, data, pos, data_valid, EA
  );

  modport slave (
    input  cmd, cmd_valid,
    output status, data, pos, data_valid, EA
  );
endinterface

// File: rtl/calc_param.sv
// Parametrised decimal calculator with serial BCD print engine.
// Optional divider enabled by defining CALC_PARAM_DIV_EN.
module calc_param #(
  parameter int DIGITS = 8,
  parameter int W      = 27,
  parameter int POS_W  = 4
) (
  input  logic        clock,
  input  logic        reset,
  calc_param_if.slave bus
);
  typedef enum logic [2:0] {
    ENTER_A = 3'b000,
    ENTER_B = 3'b001,
    COMPUTE = 3'b010,
    SHOW    = 3'b011,
    ERROR   = 3'b100
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAX64 = pow10(DIGITS) - 64'd1;
  localparam logic [W+3:0] MAX_E = MAX64[W+3:0];
  localparam logic [2*W-1:0] MAX_R = MAX64[2*W-1:0];
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(DIGITS - 1);

  state_t           ea;
  op_t              op;
  logic [W-1:0]     a, b, entry, shift;
  logic [1:0]       status;
  logic [3:0]       data;
  logic [POS_W-1:0] pos;
  logic             data_valid;
  logic [2*W-1:0]   acc, mcand, acc_nxt;
  logic [W-1:0]     mplier;
  logic [CW-1:0]    cnt;

  logic             accept, is_dig, is_bs, is_eq, is_op, fits;
  logic [W+3:0]     grown;
  logic [W-1:0]     shrunk;
  logic [1:0]       op_code;
  logic [2*W-1:0]   res;
  logic             done, bad;
  logic             print_go;
  logic [W-1:0]     print_val;

  assign bus.status     = status;
  assign bus.data       = data;
  assign bus.pos        = pos;
  assign bus.data_valid = data_valid;
  assign bus.EA         = ea;

  assign accept  = bus.cmd_valid && (status == 2'b10);
  assign is_dig  = bus.cmd <= 4'd9;
  assign is_bs   = bus.cmd == 4'd15;
  assign is_eq   = bus.cmd == 4'd14;
`ifdef CALC_PARAM_DIV_EN
  assign is_op   = (bus.cmd >= 4'd10) && (bus.cmd <= 4'd13);
`else
  assign is_op   = (bus.cmd >= 4'd10) && (bus.cmd <= 4'd12);
`endif
  assign grown   = {4'b0, entry} * (W+4)'(10) + (W+4)'(bus.cmd);
  assign fits    = grown <= MAX_E;
  assign shrunk  = entry / W'(10);
  assign op_code = bus.cmd[1:0] + 2'd2;
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

`ifdef CALC_PARAM_DIV_EN
  logic [W-1:0] rem, rem_nxt, quo, quo_nxt;
  logic [W:0]   trial;
  logic         ge;

  // One restoring-division step per cycle
  always_comb begin
    trial   = {rem, quo[W-1]};
    ge      = trial >= {1'b0, b};
    rem_nxt = ge ? W'(trial - {1'b0, b}) : trial[W-1:0];
    quo_nxt = {quo[W-2:0], ge};
  end
`endif

  // Result select, completion and error detection
  always_comb begin
    res  = '0;
    done = 1'b1;
    bad  = 1'b0;
    unique case (op)
      OP_ADD: res = (2*W)'(a) + (2*W)'(b);
      OP_SUB: begin
        res = (2*W)'(a - b);
        bad = a < b;
      end
      OP_MUL: begin
        res  = acc_nxt;
        done = cnt == LAST;
      end
      OP_DIV: begin
`ifdef CALC_PARAM_DIV_EN
        res  = (2*W)'(quo_nxt);
        bad  = b == '0;
        done = cnt == LAST;
`else
        bad  = 1'b1;
`endif
      end
    endcase
    if (res > MAX_R) bad = 1'b1;
  end

  // Decide whether this edge starts a print, and of what
  always_comb begin
    print_go  = 1'b0;
    print_val = '0;
    if (ea == COMPUTE) begin
      print_go  = done && !bad;
      print_val = res[W-1:0];
    end else if (accept) begin
      unique case (ea)
        ENTER_A, ENTER_B: begin
          if (is_dig) begin
            print_go  = fits;
            print_val = grown[W-1:0];
          end else if (is_bs) begin
            print_go  = 1'b1;
            print_val = shrunk;
          end else if (is_op) begin
            print_go  = ea == ENTER_A;
          end
        end
        SHOW: begin
          print_go  = is_dig || is_op;
          print_val = is_dig ? W'(bus.cmd) : '0;
        end
        default: ;
      endcase
    end
  end

  // Calculator FSM, datapath and print shifter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ea         <= ENTER_A;
      op         <= OP_ADD;
      a          <= '0;
      b          <= '0;
      entry      <= '0;
      shift      <= '0;
      status     <= 2'b10;
      data       <= '0;
      pos        <= '0;
      data_valid <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
`ifdef CALC_PARAM_DIV_EN
      rem        <= '0;
      quo        <= '0;
`endif
    end else begin
      if (print_go) begin
        status     <= 2'b11;
        data_valid <= 1'b1;
        pos        <= '0;
        data       <= 4'(print_val % W'(10));
        shift      <= print_val / W'(10);
      end else if (data_valid) begin
        if (pos == LAST_POS) begin
          status     <= 2'b10;
          data_valid <= 1'b0;
          pos        <= '0;
          data       <= '0;
        end else begin
          pos   <= pos + POS_W'(1);
          data  <= 4'(shift % W'(10));
          shift <= shift / W'(10);
        end
      end
      unique case (ea)
        ENTER_A: if (accept) begin
          if (is_dig) begin
            if (fits) entry <= grown[W-1:0];
          end else if (is_bs) begin
            entry <= shrunk;
          end else if (is_op) begin
            a     <= entry;
            op    <= op_t'(op_code);
            entry <= '0;
            ea    <= ENTER_B;
          end
        end
        ENTER_B: if (accept) begin
          if (is_dig) begin
            if (fits) entry <= grown[W-1:0];
          end else if (is_bs) begin
            entry <= shrunk;
          end else if (is_eq) begin
            b      <= entry;
            ea     <= COMPUTE;
            status <= 2'b01;
            acc    <= '0;
            mcand  <= (2*W)'(a);
            mplier <= entry;
            cnt    <= '0;
`ifdef CALC_PARAM_DIV_EN
            rem    <= '0;
            quo    <= a;
`endif
          end
        end
        COMPUTE: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
`ifdef CALC_PARAM_DIV_EN
          rem    <= rem_nxt;
          quo    <= quo_nxt;
`endif
          if (done) begin
            if (bad) begin
              ea     <= ERROR;
              status <= 2'b00;
            end else begin
              entry <= res[W-1:0];
              ea    <= SHOW;
            end
          end
        end
        SHOW: if (accept) begin
          if (is_dig) begin
            a     <= '0;
            entry <= W'(bus.cmd);
            ea    <= ENTER_A;
          end else if (is_op) begin
            a     <= entry;
            op    <= op_t'(op_code);
            entry <= '0;
            ea    <= ENTER_B;
          end
        end
        ERROR: begin
          status     <= 2'b00;
          data_valid <= 1'b0;
        end
        default: ea <= ERROR;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_param.sv
// Self-checking bench for calc_param against an arithmetic
// model of the calculator built from its key rules.
module tb_calc_param;
  localparam int DIGITS = 8;
  localparam int W      = 27;
  localparam int POS_W  = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  calc_param_if #(.POS_W(POS_W)) bus();

  calc_param #(
    .DIGITS(DIGITS),
    .W(W),
    .POS_W(POS_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int     n_assert = 0;
  int     n_fail   = 0;
  longint max_v;
  longint m_entry, m_a, m_b;
  int     m_op, m_st;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ea_code();
    case (m_st)
      0: return 0;
      1: return 1;
      2: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic bit op_ok(input int c);
`ifdef CALC_PARAM_DIV_EN
    return c >= 10 && c <= 13;
`else
    return c >= 10 && c <= 12;
`endif
  endfunction

  task automatic model_clear();
    m_entry = 0;
    m_a     = 0;
    m_b     = 0;
    m_op    = 10;
    m_st    = 0;
  endtask

  // kind: 0 ignored, 1 print, 2 compute ok, 3 compute error, 4 in error
  task automatic model_step(input int c, output int kind,
                            output longint val, output int cyc);
    longint r;
    bit err;
    kind = 0;
    val  = 0;
    cyc  = 0;
    if (m_st == 3) begin
      kind = 4;
    end else if (c <= 9) begin
      if (m_st == 2) begin
        m_entry = 0;
        m_a     = 0;
        m_st    = 0;
      end
      if (m_entry * 10 + c <= max_v) begin
        m_entry = m_entry * 10 + c;
        kind    = 1;
        val     = m_entry;
      end
    end else if (c == 15) begin
      if (m_st != 2) begin
        m_entry = m_entry / 10;
        kind    = 1;
        val     = m_entry;
      end
    end else if (op_ok(c)) begin
      if (m_st != 1) begin
        m_a     = m_entry;
        m_op    = c;
        m_entry = 0;
        m_st    = 1;
        kind    = 1;
      end
    end else if (c == 14 && m_st == 1) begin
      m_b = m_entry;
      cyc = (m_op >= 12) ? W : 1;
      err = 1'b0;
      r   = 0;
      case (m_op)
        10: r = m_a + m_b;
        11: if (m_a < m_b) err = 1'b1; else r = m_a - m_b;
        12: r = m_a * m_b;
        default: if (m_b == 0) err = 1'b1; else r = m_a / m_b;
      endcase
      if (r > max_v) err = 1'b1;
      if (err) begin
        m_st = 3;
        kind = 3;
      end else begin
        m_entry = r;
        m_st    = 2;
        kind    = 2;
        val     = r;
      end
    end
  endtask

  task automatic show(input longint v, input bit inject);
    for (int i = 0; i < DIGITS; i++) begin
      chk("pr_status", bus.status, 3);
      chk("pr_valid", bus.data_valid, 1);
      chk("pr_pos", bus.pos, i);
      chk("pr_data", bus.data, v % 10);
      v = v / 10;
      if (inject && i == 2) begin
        bus.cmd       = 4'd9;
        bus.cmd_valid = 1'b1;
      end
      if (inject && i == 3) bus.cmd_valid = 1'b0;
      @(negedge clock);
    end
    chk("pr_end_status", bus.status, 2);
    chk("pr_end_valid", bus.data_valid, 0);
    chk("pr_end_pos", bus.pos, 0);
  endtask

  task automatic step(input int c, input bit inject = 1'b0);
    int     kind, cyc, n;
    longint v;
    model_step(c, kind, v, cyc);
    @(negedge clock);
    bus.cmd       = 4'(c);
    bus.cmd_valid = 1'b1;
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    case (kind)
      0: begin
        chk("ign_valid", bus.data_valid, 0);
        chk("ign_status", bus.status, 2);
      end
      4: begin
        chk("err_status", bus.status, 0);
        chk("err_valid", bus.data_valid, 0);
      end
      1: show(v, inject);
      default: begin
        n = 0;
        while (bus.status == 2'b01 && n < W + 8) begin
          n++;
          @(negedge clock);
        end
        chk("busy_cycles", n, cyc);
        if (kind == 3) begin
          chk("err_status", bus.status, 0);
          chk("err_valid", bus.data_valid, 0);
        end else begin
          show(v, 1'b0);
        end
      end
    endcase
    chk("ea", bus.EA, ea_code());
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    chk("rst_status", bus.status, 2);
    chk("rst_valid", bus.data_valid, 0);
    chk("rst_ea", bus.EA, 0);
  endtask

  initial begin
    int r, c;
    bus.cmd       = '0;
    bus.cmd_valid = 1'b0;
    max_v = 1;
    repeat (DIGITS) max_v = max_v * 10;
    max_v = max_v - 1;
    model_clear();

    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_status", bus.status, 2);
    chk("rst_data", bus.data, 0);
    chk("rst_pos", bus.pos, 0);
    chk("rst_valid", bus.data_valid, 0);
    chk("rst_ea", bus.EA, 0);

    step(1); step(2); step(3);

    do_reset();
    step(4); step(5); step(10); step(7); step(14);

    do_reset();
    step(1); step(2); step(12); step(3); step(4); step(14);
    step(11); step(8); step(14);

    do_reset();
    repeat (DIGITS) step(9);
    step(9);
    step(15);
    step(14);

    do_reset();
    step(3); step(11); step(5); step(14);
    step(1); step(10); step(14); step(15);

    do_reset();
    step(5); step(7, 1'b1); step(15);
    step(10); step(11); step(14);

`ifdef CALC_PARAM_DIV_EN
    do_reset();
    step(1); step(0); step(0); step(13); step(7); step(14);
    do_reset();
    step(5); step(13); step(0); step(14);
`else
    do_reset();
    step(4); step(13); step(10); step(13); step(2);
    step(14); step(13);
`endif

    do_reset();
    @(negedge clock);
    bus.cmd       = 4'd6;
    bus.cmd_valid = 1'b1;
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    @(negedge clock);
    chk("mid_valid", bus.data_valid, 1);
    reset = 1'b1;
    #1;
    chk("abort_valid", bus.data_valid, 0);
    chk("abort_status", bus.status, 2);
    chk("abort_ea", bus.EA, 0);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    @(negedge clock);
    chk("abort_idle", bus.data_valid, 0);

    for (int k = 0; k < 200; k++) begin
      if (m_st == 3 && $urandom_range(0, 2) == 0) do_reset();
      r = int'($urandom_range(0, 99));
      if (r < 55) c = int'($urandom_range(0, 9));
      else if (r < 65) c = 15;
      else if (r < 82) c = int'($urandom_range(10, 13));
      else c = 14;
      step(c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
